// File: rtl/axi_ic_pkg.sv
// axi_ic_pkg: shared response codes, FSM encodings and index-width helper for the interconnect
package axi_ic_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_FWD  = 2'd1;
  localparam logic [1:0] W_ERR  = 2'd2;
  localparam logic [1:0] W_RESP = 2'd3;
  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_FWD  = 2'd1;
  localparam logic [1:0] R_RESP = 2'd2;
  localparam logic [1:0] R_ERR  = 2'd3;
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/axi_ic_addr_decoder.sv
// axi_ic_addr_decoder: base/mask address decode, lowest-index hit wins
module axi_ic_addr_decoder
  import axi_ic_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_SLAVES = 2,
  localparam int IW = clog2(NUM_SLAVES)
) (
  input  logic [ADDR_WIDTH-1:0]            addr,
  input  logic [NUM_SLAVES*ADDR_WIDTH-1:0] base_addr,
  input  logic [NUM_SLAVES*ADDR_WIDTH-1:0] addr_mask,
  output logic                             hit,
  output logic [IW-1:0]                    index
);
  always_comb begin
    hit = 1'b0;
    index = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--)
      if ((addr & addr_mask[i*ADDR_WIDTH +: ADDR_WIDTH]) == base_addr[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit = 1'b1;
        index = IW'(i);
      end
  end
endmodule

// File: rtl/axi_interconnect_1xn.sv
// axi_interconnect_1xn: 1-master / N-slave AXI4-Lite interconnect with independent
// write/read locking and an internal DECERR responder for unmapped addresses
module axi_interconnect_1xn
  import axi_ic_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 2,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] BASE_ADDR = {32'h4000_1000, 32'h4000_0000},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] ADDR_MASK = {32'hFFFF_F000, 32'hFFFF_F000}
) (
  input  logic                               ACLK,
  input  logic                               ARESET,
  input  logic [ADDR_WIDTH-1:0]              M_AWADDR,
  input  logic                               M_AWVALID,
  output logic                               M_AWREADY,
  input  logic [DATA_WIDTH-1:0]              M_WDATA,
  input  logic [DATA_WIDTH/8-1:0]            M_WSTRB,
  input  logic                               M_WVALID,
  output logic                               M_WREADY,
  output logic [1:0]                         M_BRESP,
  output logic                               M_BVALID,
  input  logic                               M_BREADY,
  input  logic [ADDR_WIDTH-1:0]              M_ARADDR,
  input  logic                               M_ARVALID,
  output logic                               M_ARREADY,
  output logic [DATA_WIDTH-1:0]              M_RDATA,
  output logic [1:0]                         M_RRESP,
  output logic                               M_RVALID,
  input  logic                               M_RREADY,
  output logic [NUM_SLAVES*ADDR_WIDTH-1:0]   S_AWADDR,
  output logic [NUM_SLAVES-1:0]              S_AWVALID,
  input  logic [NUM_SLAVES-1:0]              S_AWREADY,
  output logic [NUM_SLAVES*DATA_WIDTH-1:0]   S_WDATA,
  output logic [NUM_SLAVES*DATA_WIDTH/8-1:0] S_WSTRB,
  output logic [NUM_SLAVES-1:0]              S_WVALID,
  input  logic [NUM_SLAVES-1:0]              S_WREADY,
  input  logic [NUM_SLAVES*2-1:0]            S_BRESP,
  input  logic [NUM_SLAVES-1:0]              S_BVALID,
  output logic [NUM_SLAVES-1:0]              S_BREADY,
  output logic [NUM_SLAVES*ADDR_WIDTH-1:0]   S_ARADDR,
  output logic [NUM_SLAVES-1:0]              S_ARVALID,
  input  logic [NUM_SLAVES-1:0]              S_ARREADY,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0]   S_RDATA,
  input  logic [NUM_SLAVES*2-1:0]            S_RRESP,
  input  logic [NUM_SLAVES-1:0]              S_RVALID,
  output logic [NUM_SLAVES-1:0]              S_RREADY
);
  localparam int IW = clog2(NUM_SLAVES);
  localparam int SW = DATA_WIDTH / 8;
  logic [1:0] wstate, rstate;
  logic [ADDR_WIDTH-1:0] waddr, raddr;
  logic [IW-1:0] widx, ridx, aw_idx, ar_idx;
  logic wmiss, aw_done, w_done, aw_hit, ar_hit, aw_fin, w_fin;
  logic [1:0] bresp [NUM_SLAVES];
  logic [1:0] rresp [NUM_SLAVES];
  logic [DATA_WIDTH-1:0] rdata [NUM_SLAVES];
  axi_ic_addr_decoder #(.ADDR_WIDTH(ADDR_WIDTH), .NUM_SLAVES(NUM_SLAVES)) u_aw_dec (
    .addr(M_AWADDR), .base_addr(BASE_ADDR), .addr_mask(ADDR_MASK), .hit(aw_hit), .index(aw_idx)
  );
  axi_ic_addr_decoder #(.ADDR_WIDTH(ADDR_WIDTH), .NUM_SLAVES(NUM_SLAVES)) u_ar_dec (
    .addr(M_ARADDR), .base_addr(BASE_ADDR), .addr_mask(ADDR_MASK), .hit(ar_hit), .index(ar_idx)
  );
  // Address/data buses are broadcast; only the locked slave ever sees a valid or ready.
  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_s
    assign bresp[i] = S_BRESP[2*i +: 2];
    assign rresp[i] = S_RRESP[2*i +: 2];
    assign rdata[i] = S_RDATA[i*DATA_WIDTH +: DATA_WIDTH];
    assign S_AWADDR[i*ADDR_WIDTH +: ADDR_WIDTH] = waddr;
    assign S_ARADDR[i*ADDR_WIDTH +: ADDR_WIDTH] = raddr;
    assign S_WDATA[i*DATA_WIDTH +: DATA_WIDTH] = M_WDATA;
    assign S_WSTRB[i*SW +: SW] = M_WSTRB;
    assign S_AWVALID[i] = (wstate == W_FWD) && !aw_done && (widx == IW'(i));
    assign S_WVALID[i] = (wstate == W_FWD) && !w_done && (widx == IW'(i)) && M_WVALID;
    assign S_BREADY[i] = (wstate == W_RESP) && !wmiss && (widx == IW'(i)) && M_BREADY;
    assign S_ARVALID[i] = (rstate == R_FWD) && (ridx == IW'(i));
    assign S_RREADY[i] = (rstate == R_RESP) && (ridx == IW'(i)) && M_RREADY;
  end
  assign M_AWREADY = wstate == W_IDLE;
  assign M_WREADY = (wstate == W_ERR) || ((wstate == W_FWD) && !w_done && S_WREADY[widx]);
  assign M_BVALID = (wstate == W_RESP) && (wmiss || S_BVALID[widx]);
  assign M_BRESP = wmiss ? RESP_DECERR : bresp[widx];
  assign M_ARREADY = rstate == R_IDLE;
  assign M_RVALID = (rstate == R_ERR) || ((rstate == R_RESP) && S_RVALID[ridx]);
  assign M_RDATA = (rstate == R_ERR) ? '0 : rdata[ridx];
  assign M_RRESP = (rstate == R_ERR) ? RESP_DECERR : rresp[ridx];
  assign aw_fin = aw_done || S_AWREADY[widx];
  assign w_fin = w_done || (M_WVALID && S_WREADY[widx]);
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      wstate <= W_IDLE;
      waddr <= '0;
      widx <= '0;
      wmiss <= 1'b0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
    end else
      case (wstate)
        W_IDLE:
          if (M_AWVALID) begin
            waddr <= M_AWADDR;
            widx <= aw_idx;
            wmiss <= !aw_hit;
            aw_done <= 1'b0;
            w_done <= 1'b0;
            wstate <= aw_hit ? W_FWD : W_ERR;
          end
        W_FWD: begin
          aw_done <= aw_fin;
          w_done <= w_fin;
          if (aw_fin && w_fin) wstate <= W_RESP;
        end
        W_ERR: if (M_WVALID) wstate <= W_RESP;
        default: if (M_BVALID && M_BREADY) wstate <= W_IDLE;
      endcase
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      rstate <= R_IDLE;
      raddr <= '0;
      ridx <= '0;
    end else
      case (rstate)
        R_IDLE:
          if (M_ARVALID) begin
            raddr <= M_ARADDR;
            ridx <= ar_idx;
            rstate <= ar_hit ? R_FWD : R_ERR;
          end
        R_FWD: if (S_ARREADY[ridx]) rstate <= R_RESP;
        default: if (M_RVALID && M_RREADY) rstate <= R_IDLE;
      endcase
endmodule

// File: tb/tb_axi_interconnect_1xn.sv
// tb_axi_interconnect_1xn: directed vector table plus hand sequences against two behavioural slaves
module tb_axi_interconnect_1xn;
  localparam int AW = 32, DW = 32, NS = 2;
  logic ACLK = 1'b0, ARESET = 1'b1;
  always #5 ACLK = ~ACLK;
  logic [AW-1:0] M_AWADDR, M_ARADDR;
  logic M_AWVALID, M_AWREADY, M_WVALID, M_WREADY, M_BVALID, M_BREADY;
  logic M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;
  logic [DW-1:0] M_WDATA, M_RDATA;
  logic [DW/8-1:0] M_WSTRB;
  logic [1:0] M_BRESP, M_RRESP;
  logic [NS*AW-1:0] S_AWADDR, S_ARADDR;
  logic [NS*DW-1:0] S_WDATA, S_RDATA;
  logic [NS*DW/8-1:0] S_WSTRB;
  logic [NS*2-1:0] S_BRESP, S_RRESP;
  logic [NS-1:0] S_AWVALID, S_AWREADY, S_WVALID, S_WREADY, S_BVALID, S_BREADY;
  logic [NS-1:0] S_ARVALID, S_ARREADY, S_RVALID, S_RREADY;
  axi_interconnect_1xn dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
    .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
    .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY),
    .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY)
  );
  int aw_dly;
  logic [1:0] cfg_bresp, cfg_rresp;
  logic [31:0] cfg_rdata;
  logic [NS-1:0] stray_b, awr, arr, bv, rv, got_aw, got_w;
  int acnt [NS];
  logic [1:0] br [NS];
  logic [1:0] rr [NS];
  logic [31:0] rd [NS];
  logic [31:0] wgot [NS];
  assign S_AWREADY = awr;
  assign S_WREADY = '1;
  assign S_ARREADY = arr;
  assign S_BVALID = bv | stray_b;
  assign S_RVALID = rv;
  assign S_BRESP = {br[1], br[0]};
  assign S_RRESP = {rr[1], rr[0]};
  assign S_RDATA = {rd[1], rd[0]};
  // behavioural slaves: AWREADY after aw_dly cycles, ARREADY after one, B/R one cycle after completion
  always @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      awr <= '0; arr <= '0; bv <= '0; rv <= '0; got_aw <= '0; got_w <= '0;
      for (int i = 0; i < NS; i++) begin
        acnt[i] <= 0; br[i] <= '0; rr[i] <= '0; rd[i] <= '0;
      end
    end else
      for (int i = 0; i < NS; i++) begin
        if (S_AWVALID[i] && awr[i]) begin
          awr[i] <= 1'b0; acnt[i] <= 0; got_aw[i] <= 1'b1;
        end else if (S_AWVALID[i]) begin
          if (acnt[i] == aw_dly) awr[i] <= 1'b1;
          else acnt[i] <= acnt[i] + 1;
        end
        if (S_WVALID[i]) begin
          got_w[i] <= 1'b1; wgot[i] <= S_WDATA[i*DW +: DW];
        end
        if (got_aw[i] && got_w[i] && !bv[i]) begin
          bv[i] <= 1'b1; br[i] <= cfg_bresp; got_aw[i] <= 1'b0; got_w[i] <= 1'b0;
        end
        if (bv[i] && S_BREADY[i]) bv[i] <= 1'b0;
        if (S_ARVALID[i] && arr[i]) begin
          arr[i] <= 1'b0; rv[i] <= 1'b1; rd[i] <= cfg_rdata; rr[i] <= cfg_rresp;
        end else if (S_ARVALID[i]) arr[i] <= 1'b1;
        if (rv[i] && S_RREADY[i]) rv[i] <= 1'b0;
      end
  int c_awv [NS] = '{default: 0};
  int c_wv [NS] = '{default: 0};
  int c_arv [NS] = '{default: 0};
  int c_bready1 = 0, c_mbv = 0;
  always @(posedge ACLK) begin
    for (int i = 0; i < NS; i++) begin
      c_awv[i] <= c_awv[i] + 32'(S_AWVALID[i]);
      c_wv[i] <= c_wv[i] + 32'(S_WVALID[i]);
      c_arv[i] <= c_arv[i] + 32'(S_ARVALID[i]);
    end
    c_bready1 <= c_bready1 + 32'(S_BREADY[1]);
    c_mbv <= c_mbv + 32'(M_BVALID);
  end
  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic xfer(input logic dw, input logic dr, input logic [31:0] wa, input logic [31:0] wd,
                      input logic [31:0] ra, input int wlead, input int rstall,
                      output logic [1:0] bresp_o, output logic [1:0] rresp_o, output logic [31:0] rdata_o,
                      output int early_wr, output int unstable);
    int cyc, stalls;
    logic bd, rdn, haw, hw, hb, har, hr;
    logic [31:0] held;
    cyc = 0; stalls = 0; early_wr = 0; unstable = 0; held = '0;
    bd = !dw; rdn = !dr;
    bresp_o = 2'bxx; rresp_o = 2'bxx; rdata_o = 'x;
    M_AWADDR = wa; M_WDATA = wd; M_WSTRB = '1; M_ARADDR = ra;
    M_AWVALID = dw && (wlead == 0); M_WVALID = dw; M_BREADY = dw;
    M_ARVALID = dr; M_RREADY = dr && (rstall == 0);
    while (!(bd && rdn) && cyc < 200) begin
      #1;
      haw = M_AWVALID && M_AWREADY; hw = M_WVALID && M_WREADY; hb = M_BVALID && M_BREADY;
      har = M_ARVALID && M_ARREADY; hr = M_RVALID && M_RREADY;
      if (dw && cyc < wlead && M_WREADY) early_wr++;
      if (hb) begin bresp_o = M_BRESP; bd = 1'b1; end
      if (hr) begin rresp_o = M_RRESP; rdata_o = M_RDATA; rdn = 1'b1; end
      if (M_RVALID && !M_RREADY) begin
        if (stalls == 0) held = M_RDATA;
        else if (M_RDATA !== held) unstable++;
        stalls++;
      end
      @(negedge ACLK);
      cyc++;
      if (haw) M_AWVALID = 1'b0;
      if (hw) M_WVALID = 1'b0;
      if (hb) M_BREADY = 1'b0;
      if (har) M_ARVALID = 1'b0;
      if (hr) M_RREADY = 1'b0;
      if (dw && wlead > 0 && cyc == wlead) M_AWVALID = 1'b1;
      if (dr && !rdn && stalls >= rstall) M_RREADY = 1'b1;
    end
    chk("xfer_timeout", 32'(cyc >= 200), 0);
    M_AWVALID = 0; M_WVALID = 0; M_BREADY = 0; M_ARVALID = 0; M_RREADY = 0;
  endtask
  typedef struct {
    logic rdn;
    logic [31:0] addr;
    logic [31:0] data;
    int dly;
    logic [1:0] sresp;
    logic [1:0] eresp;
    logic [31:0] edata;
    int ev0, ev1, ew0, ew1;
  } vec_t;
  vec_t vecs [8];
  initial begin
    logic [1:0] b, r;
    logic [31:0] d;
    int e, u, s_awv0, s_awv1, s_wv0, s_wv1, s_arv0, s_arv1, s_br1, s_mbv;
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic [1:0] b, r;
    logic [31:0] d;
    int e, u, s_awv0, s_awv1, s_wv0, s_wv1, s_arv0, s_arv1, s_br1, s_mbv;
    vecs[0] = '{1'b0, 32'h4000_0004, 32'hDEAD_BEEF, 3, 2'b00, 2'b00, 32'hDEAD_BEEF, 5, 0, 1, 0};
    vecs[1] = '{1'b1, 32'h4000_1008, 32'h1234_5678, 0, 2'b00, 2'b00, 32'h1234_5678, 0, 2, 0, 0};
    vecs[2] = '{1'b0, 32'h5000_0000, 32'hCAFE_F00D, 0, 2'b00, 2'b11, 32'h0, 0, 0, 0, 0};
    vecs[3] = '{1'b1, 32'h5000_0000, 32'h1111_2222, 0, 2'b00, 2'b11, 32'h0, 0, 0, 0, 0};
    vecs[4] = '{1'b0, 32'h4000_1010, 32'h0BAD_CAFE, 1, 2'b10, 2'b10, 32'h0BAD_CAFE, 0, 3, 0, 1};
    vecs[5] = '{1'b1, 32'h4000_0FFC, 32'hA5A5_5A5A, 0, 2'b10, 2'b10, 32'hA5A5_5A5A, 2, 0, 0, 0};
    vecs[6] = '{1'b0, 32'h4000_2000, 32'h7777_7777, 0, 2'b00, 2'b11, 32'h0, 0, 0, 0, 0};
    vecs[7] = '{1'b1, 32'h3FFF_FFFC, 32'h8888_8888, 0, 2'b00, 2'b11, 32'h0, 0, 0, 0, 0};
    M_AWADDR = 0; M_AWVALID = 0; M_WDATA = 0; M_WSTRB = 0; M_WVALID = 0; M_BREADY = 0;
    M_ARADDR = 0; M_ARVALID = 0; M_RREADY = 0;
    stray_b = '0; aw_dly = 0; cfg_bresp = 0; cfg_rresp = 0; cfg_rdata = 0;
    repeat (3) @(negedge ACLK);
    chk("rst_awready", 32'(M_AWREADY), 1);
    chk("rst_arready", 32'(M_ARREADY), 1);
    chk("rst_wready", 32'(M_WREADY), 0);
    chk("rst_bvalid", 32'(M_BVALID), 0);
    chk("rst_rvalid", 32'(M_RVALID), 0);
    chk("rst_s_awvalid", 32'(S_AWVALID), 0);
    chk("rst_s_arvalid", 32'(S_ARVALID), 0);
    chk("rst_s_bready", 32'(S_BREADY), 0);
    ARESET = 0;
    @(negedge ACLK);
    for (int k = 0; k < 8; k++) begin
      aw_dly = vecs[k].dly;
      cfg_bresp = vecs[k].sresp; cfg_rresp = vecs[k].sresp; cfg_rdata = vecs[k].data;
      s_awv0 = c_awv[0]; s_awv1 = c_awv[1]; s_wv0 = c_wv[0]; s_wv1 = c_wv[1];
      s_arv0 = c_arv[0]; s_arv1 = c_arv[1];
      xfer(!vecs[k].rdn, vecs[k].rdn, vecs[k].addr, vecs[k].data, vecs[k].addr, 0, 0, b, r, d, e, u);
      chk($sformatf("v%0d_resp", k), 32'(vecs[k].rdn ? r : b), 32'(vecs[k].eresp));
      if (vecs[k].rdn) chk($sformatf("v%0d_rdata", k), d, vecs[k].edata);
      else if (vecs[k].ew0 + vecs[k].ew1 > 0)
        chk($sformatf("v%0d_wdata", k), wgot[vecs[k].ew1 > 0 ? 1 : 0], vecs[k].edata);
      chk($sformatf("v%0d_awv0", k), c_awv[0] - s_awv0, vecs[k].rdn ? 0 : vecs[k].ev0);
      chk($sformatf("v%0d_awv1", k), c_awv[1] - s_awv1, vecs[k].rdn ? 0 : vecs[k].ev1);
      chk($sformatf("v%0d_arv0", k), c_arv[0] - s_arv0, vecs[k].rdn ? vecs[k].ev0 : 0);
      chk($sformatf("v%0d_arv1", k), c_arv[1] - s_arv1, vecs[k].rdn ? vecs[k].ev1 : 0);
      chk($sformatf("v%0d_wv0", k), c_wv[0] - s_wv0, vecs[k].ew0);
      chk($sformatf("v%0d_wv1", k), c_wv[1] - s_wv1, vecs[k].ew1);
    end
    // W leads AW by two cycles while slave 1 raises a stray BVALID
    aw_dly = 0; cfg_bresp = 2'b00; stray_b = 2'b10;
    s_br1 = c_bready1; s_mbv = c_mbv;
    xfer(1, 0, 32'h4000_0010, 32'h0000_55AA, 0, 2, 0, b, r, d, e, u);
    chk("lead_early_wready", e, 0);
    chk("lead_bresp", 32'(b), 0);
    chk("lead_wdata", wgot[0], 32'h0000_55AA);
    chk("stray_bready1", c_bready1 - s_br1, 0);
    chk("stray_mbvalid_cycles", c_mbv - s_mbv, 1);
    stray_b = '0;
    // concurrent write to slave 0 and read from slave 1 with a 4-cycle R stall
    aw_dly = 2; cfg_rdata = 32'h1234_5678; cfg_rresp = 2'b00; cfg_bresp = 2'b00;
    s_awv0 = c_awv[0]; s_arv1 = c_arv[1]; s_arv0 = c_arv[0]; s_awv1 = c_awv[1];
    xfer(1, 1, 32'h4000_0020, 32'h1357_9BDF, 32'h4000_1004, 0, 4, b, r, d, e, u);
    chk("conc_bresp", 32'(b), 0);
    chk("conc_rresp", 32'(r), 0);
    chk("conc_rdata", d, 32'h1234_5678);
    chk("conc_rdata_stable", u, 0);
    chk("conc_awv0", c_awv[0] - s_awv0, 4);
    chk("conc_arv1", c_arv[1] - s_arv1, 2);
    chk("conc_arv0", c_arv[0] - s_arv0, 0);
    chk("conc_awv1", c_awv[1] - s_awv1, 0);
    // reset asserted while the write is in W_FWD
    aw_dly = 10;
    M_AWADDR = 32'h4000_0030; M_AWVALID = 1; M_WDATA = 32'h0F0F_0F0F; M_WSTRB = '1;
    M_WVALID = 1; M_BREADY = 1;
    @(negedge ACLK);
    M_AWVALID = 0;
    #1;
    chk("fwd_s_awvalid", 32'(S_AWVALID), 32'h1);
    chk("fwd_s_wvalid", 32'(S_WVALID), 32'h1);
    chk("fwd_awready", 32'(M_AWREADY), 0);
    #2 ARESET = 1;
    #1;
    chk("arst_s_awvalid", 32'(S_AWVALID), 0);
    chk("arst_s_wvalid", 32'(S_WVALID), 0);
    chk("arst_awready", 32'(M_AWREADY), 1);
    chk("arst_wready", 32'(M_WREADY), 0);
    chk("arst_bvalid", 32'(M_BVALID), 0);
    @(negedge ACLK);
    ARESET = 0; M_WVALID = 0; M_BREADY = 0;
    @(negedge ACLK);
    chk("post_rst_awready", 32'(M_AWREADY), 1);
    aw_dly = 0; s_mbv = c_mbv;
    xfer(1, 0, 32'h4000_0034, 32'hFEED_F00D, 0, 0, 0, b, r, d, e, u);
    chk("post_rst_bresp", 32'(b), 0);
    chk("post_rst_wdata", wgot[0], 32'hFEED_F00D);
    chk("post_rst_mbvalid_cycles", c_mbv - s_mbv, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
